// File: rtl/bp_be_stride_prefetch_gen_if.sv
// Loop-descriptor / prefetch bundle between loop inference, the prefetch
// generator and the D-cache prefetch port.
interface bp_be_stride_prefetch_gen_if
  #(parameter int vaddr_width_p  = 39
   ,parameter int output_range_p = 8
   ,parameter int stride_width_p = 8
   );

  // Loop descriptor (v/yumi)
  logic                      v_i;
  logic [output_range_p-1:0] remaining_iterations_i;
  logic [vaddr_width_p-1:0]  pc_i;
  logic [vaddr_width_p-1:0]  eff_addr_i;
  logic [stride_width_p-1:0] stride_i;
  logic                      yumi_o;

  // Stream control and demand-load feedback
  logic                      cancel_i;
  logic                      demand_v_i;
  logic [vaddr_width_p-1:0]  demand_pc_i;

  // Prefetch request (valid/ready)
  logic                      pf_v_o;
  logic [vaddr_width_p-1:0]  pf_vaddr_o;
  logic                      pf_ready_and_i;
  logic                      busy_o;

  modport master
    (output v_i, remaining_iterations_i, pc_i, eff_addr_i, stride_i
    ,output cancel_i, demand_v_i, demand_pc_i, pf_ready_and_i
    ,input  yumi_o, pf_v_o, pf_vaddr_o, busy_o
    );

  modport slave
    (input  v_i, remaining_iterations_i, pc_i, eff_addr_i, stride_i
    ,input  cancel_i, demand_v_i, demand_pc_i, pf_ready_and_i
    ,output yumi_o, pf_v_o, pf_vaddr_o, busy_o
    );

endinterface

// File: rtl/bp_be_stride_prefetch_gen.sv
// Stride prefetch generator: expands one loop descriptor into a stream of
// line-aligned prefetch addresses, deduplicated per cache line, stopping at
// page boundaries and throttled against demand loads at the striding PC.
module bp_be_stride_prefetch_gen
  #(parameter int vaddr_width_p       = 39
   ,parameter int output_range_p      = 8
   ,parameter int stride_width_p      = 8
   ,parameter int distance_p          = 4
   ,parameter int line_offset_width_p = 6
   ,parameter int page_offset_width_p = 12
   )
  (input logic                      clk_i
  ,input logic                      reset_n_i
  ,bp_be_stride_prefetch_gen_if.slave io
  );

  localparam int line_w_lp = vaddr_width_p - line_offset_width_p;
  localparam int page_w_lp = vaddr_width_p - page_offset_width_p;
  localparam logic [3:0] distance_lp = 4'(distance_p);

  typedef enum logic [2:0] {
    e_idle, e_drop, e_calc, e_issue, e_throttle
  } state_e;

  state_e state_r, state_n;

  logic [vaddr_width_p-1:0]  pc_r, cur_r;
  logic [stride_width_p-1:0] stride_r;
  logic [output_range_p-1:0] cnt_r;
  logic [3:0]                ahead_r;
  logic [line_w_lp-1:0]      last_line_r;
  logic [page_w_lp-1:0]      page_r;

  logic [vaddr_width_p-1:0]  stride_ext, next_addr;
  logic [line_w_lp-1:0]      next_line;
  logic [page_w_lp-1:0]      next_page;
  logic                      accept, skip, issue_hs, demand_match;

  assign stride_ext = {{(vaddr_width_p-stride_width_p){stride_r[stride_width_p-1]}}, stride_r};
  assign next_addr  = cur_r + stride_ext;
  assign next_line  = next_addr[vaddr_width_p-1:line_offset_width_p];
  assign next_page  = next_addr[vaddr_width_p-1:page_offset_width_p];

  assign demand_match = (state_r != e_idle) & io.demand_v_i & (io.demand_pc_i == pc_r);

  assign io.pf_vaddr_o = {next_line, {line_offset_width_p{1'b0}}};
  assign io.busy_o     = (state_r != e_idle);

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= e_idle;
    else            state_r <= state_n;
  end

  // Next-state, handshake outputs and datapath enables
  always_comb begin
    state_n   = state_r;
    accept    = 1'b0;
    skip      = 1'b0;
    issue_hs  = 1'b0;
    io.yumi_o = 1'b0;
    io.pf_v_o = 1'b0;
    unique case (state_r)
      e_idle: begin
        io.yumi_o = io.v_i & ~io.cancel_i;
        accept    = io.yumi_o;
        if (accept)
          state_n = ((io.remaining_iterations_i == '0) || (io.stride_i == '0)) ? e_drop : e_calc;
      end
      e_drop: state_n = e_idle;
      e_calc: begin
        if (next_page != page_r)
          state_n = e_idle;
        else if (next_line == last_line_r) begin
          skip = ~io.cancel_i;
          if (cnt_r <= output_range_p'(1)) state_n = e_idle;
        end
        else if (ahead_r == distance_lp)
          state_n = e_throttle;
        else
          state_n = e_issue;
      end
      e_issue: begin
        io.pf_v_o = 1'b1;
        if (io.pf_ready_and_i) begin
          issue_hs = 1'b1;
          state_n  = (cnt_r <= output_range_p'(1)) ? e_idle : e_calc;
        end
      end
      e_throttle: if (ahead_r < distance_lp) state_n = e_calc;
      default: state_n = e_idle;
    endcase
    // A handshake in the cancel cycle still updates the datapath above;
    // only the state is overridden so nothing further is requested.
    if (io.cancel_i) state_n = e_idle;
  end

  // Descriptor latch, stream cursor and lead counter
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pc_r        <= '0;
      cur_r       <= '0;
      stride_r    <= '0;
      cnt_r       <= '0;
      ahead_r     <= '0;
      last_line_r <= '0;
      page_r      <= '0;
    end
    else if (accept) begin
      pc_r        <= io.pc_i;
      cur_r       <= io.eff_addr_i;
      stride_r    <= io.stride_i;
      cnt_r       <= io.remaining_iterations_i;
      ahead_r     <= '0;
      last_line_r <= io.eff_addr_i[vaddr_width_p-1:line_offset_width_p];
      page_r      <= io.eff_addr_i[vaddr_width_p-1:page_offset_width_p];
    end
    else begin
      if (skip || issue_hs) begin
        cur_r <= next_addr;
        if (cnt_r != '0) cnt_r <= cnt_r - output_range_p'(1);
      end
      if (issue_hs) last_line_r <= next_line;
      // Simultaneous issue and demand leave the lead unchanged
      if (issue_hs && !demand_match)
        ahead_r <= ahead_r + 4'd1;
      else if (!issue_hs && demand_match && (ahead_r != '0))
        ahead_r <= ahead_r - 4'd1;
    end
  end

endmodule

// File: tb/tb_bp_be_stride_prefetch_gen.sv
// Directed bench for the stride prefetch generator: one instance with the
// default lead distance, one with distance 2 for throttling.
module tb_bp_be_stride_prefetch_gen;

  localparam int VW = 39;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_be_stride_prefetch_gen_if #(.vaddr_width_p(VW), .output_range_p(8), .stride_width_p(8)) ia ();
  bp_be_stride_prefetch_gen_if #(.vaddr_width_p(VW), .output_range_p(8), .stride_width_p(8)) ib ();

  bp_be_stride_prefetch_gen #(.vaddr_width_p(VW), .output_range_p(8), .stride_width_p(8),
    .distance_p(4), .line_offset_width_p(6), .page_offset_width_p(12))
    dut_a (.clk_i(clk), .reset_n_i(rst_n), .io(ia));

  bp_be_stride_prefetch_gen #(.vaddr_width_p(VW), .output_range_p(8), .stride_width_p(8),
    .distance_p(2), .line_offset_width_p(6), .page_offset_width_p(12))
    dut_b (.clk_i(clk), .reset_n_i(rst_n), .io(ib));

  int checks = 0;
  int errors = 0;

  logic [VW-1:0] a_log[$];
  logic [VW-1:0] b_log[$];
  int a_yumis = 0;

  always @(posedge clk) begin
    if (ia.pf_v_o && ia.pf_ready_and_i) a_log.push_back(ia.pf_vaddr_o);
    if (ib.pf_v_o && ib.pf_ready_and_i) b_log.push_back(ib.pf_vaddr_o);
    if (ia.yumi_o) a_yumis++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic desc_a(input logic [VW-1:0] eff, input logic [7:0] stride, input logic [7:0] rem);
    ia.v_i = 1'b1;
    ia.eff_addr_i = eff;
    ia.pc_i = 39'h200;
    ia.stride_i = stride;
    ia.remaining_iterations_i = rem;
  endtask

  task automatic wait_idle_a(input string tag, input int max_cycles);
    int n = 0;
    while (ia.busy_o && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    #1 chk(tag, ia.busy_o, 0);
  endtask

  int base, ybase;

  initial begin
    ia.v_i = 0; ia.remaining_iterations_i = 0; ia.pc_i = 0; ia.eff_addr_i = 0; ia.stride_i = 0;
    ia.cancel_i = 0; ia.demand_v_i = 0; ia.demand_pc_i = 0; ia.pf_ready_and_i = 0;
    ib.v_i = 0; ib.remaining_iterations_i = 0; ib.pc_i = 0; ib.eff_addr_i = 0; ib.stride_i = 0;
    ib.cancel_i = 0; ib.demand_v_i = 0; ib.demand_pc_i = 0; ib.pf_ready_and_i = 0;

    // Reset state
    #12;
    chk("rst_yumi", ia.yumi_o, 0);
    chk("rst_pf_v", ia.pf_v_o, 0);
    chk("rst_pf_vaddr", ia.pf_vaddr_o, 0);
    chk("rst_busy", ia.busy_o, 0);
    chk("rst_busy_b", ib.busy_o, 0);
    @(negedge clk) rst_n = 1'b1;
    ia.pf_ready_and_i = 1'b1;
    ib.pf_ready_and_i = 1'b1;

    // Basic +64 stream, one request every two cycles
    @(negedge clk);
    base = a_log.size(); ybase = a_yumis;
    desc_a(39'h1000, 8'd64, 8'd3);
    #1 chk("t1_yumi", ia.yumi_o, 1);
    @(negedge clk) ia.v_i = 1'b0;
    #1 chk("t1_calc_pfv", ia.pf_v_o, 0);
    chk("t1_busy", ia.busy_o, 1);
    @(negedge clk) #1 chk("t1_req0_v", ia.pf_v_o, 1);
    chk("t1_req0_a", ia.pf_vaddr_o, 39'h1040);
    @(negedge clk) #1 chk("t1_gap0", ia.pf_v_o, 0);
    @(negedge clk) #1 chk("t1_req1_v", ia.pf_v_o, 1);
    chk("t1_req1_a", ia.pf_vaddr_o, 39'h1080);
    @(negedge clk) #1 chk("t1_gap1", ia.pf_v_o, 0);
    @(negedge clk) #1 chk("t1_req2_v", ia.pf_v_o, 1);
    chk("t1_req2_a", ia.pf_vaddr_o, 39'h10C0);
    @(negedge clk) #1 chk("t1_end_pfv", ia.pf_v_o, 0);
    chk("t1_end_busy", ia.busy_o, 0);
    chk("t1_yumi_once", a_yumis - ybase, 1);
    chk("t1_count", a_log.size() - base, 3);

    // +8 stride: same-line steps are skipped
    @(negedge clk);
    base = a_log.size();
    desc_a(39'h1000, 8'd8, 8'd16);
    @(negedge clk) ia.v_i = 1'b0;
    wait_idle_a("t2_idle", 60);
    chk("t2_count", a_log.size() - base, 2);
    if (a_log.size() - base == 2) begin
      chk("t2_a0", a_log[base], 39'h1040);
      chk("t2_a1", a_log[base+1], 39'h1080);
    end

    // First step crosses the page: nothing issued
    @(negedge clk);
    base = a_log.size();
    desc_a(39'h1FC0, 8'd64, 8'd5);
    @(negedge clk) ia.v_i = 1'b0;
    #1 chk("t3_calc_busy", ia.busy_o, 1);
    chk("t3_calc_pfv", ia.pf_v_o, 0);
    @(negedge clk) #1 chk("t3_idle", ia.busy_o, 0);
    chk("t3_count", a_log.size() - base, 0);

    // Throttling at distance 2
    @(negedge clk);
    base = b_log.size();
    ib.v_i = 1'b1; ib.eff_addr_i = 39'h3000; ib.pc_i = 39'h400;
    ib.stride_i = 8'd64; ib.remaining_iterations_i = 8'd6;
    @(negedge clk) ib.v_i = 1'b0;
    repeat (12) @(negedge clk);
    #1 chk("t4_count2", b_log.size() - base, 2);
    chk("t4_stall_pfv", ib.pf_v_o, 0);
    chk("t4_stall_busy", ib.busy_o, 1);
    if (b_log.size() - base >= 2) begin
      chk("t4_a0", b_log[base], 39'h3040);
      chk("t4_a1", b_log[base+1], 39'h3080);
    end
    @(negedge clk) ib.demand_v_i = 1'b1; ib.demand_pc_i = 39'h404;
    @(negedge clk) ib.demand_v_i = 1'b0;
    repeat (10) @(negedge clk);
    #1 chk("t4_nomatch", b_log.size() - base, 2);
    @(negedge clk) ib.demand_v_i = 1'b1; ib.demand_pc_i = 39'h400;
    @(negedge clk) ib.demand_v_i = 1'b0;
    repeat (10) @(negedge clk);
    #1 chk("t4_match", b_log.size() - base, 3);
    if (b_log.size() - base == 3) chk("t4_a2", b_log[base+2], 39'h30C0);
    chk("t4_restall_busy", ib.busy_o, 1);
    @(negedge clk) ib.cancel_i = 1'b1;
    @(negedge clk) ib.cancel_i = 1'b0;
    #1 chk("t4_cancel_idle", ib.busy_o, 0);

    // Backpressure with negative stride, then cancel
    @(negedge clk);
    base = a_log.size();
    ia.pf_ready_and_i = 1'b0;
    desc_a(39'h1100, 8'hC0, 8'd4);
    @(negedge clk) ia.v_i = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1 chk("t5_hold_v", ia.pf_v_o, 1);
      chk("t5_hold_a", ia.pf_vaddr_o, 39'h10C0);
      @(negedge clk);
    end
    ia.cancel_i = 1'b1;
    @(negedge clk) ia.cancel_i = 1'b0;
    #1 chk("t5_cancel_pfv", ia.pf_v_o, 0);
    chk("t5_cancel_busy", ia.busy_o, 0);
    chk("t5_none", a_log.size() - base, 0);
    ia.pf_ready_and_i = 1'b1;
    desc_a(39'h5000, 8'd64, 8'd1);
    #1 chk("t5_new_yumi", ia.yumi_o, 1);
    @(negedge clk) ia.v_i = 1'b0;
    wait_idle_a("t5_new_idle", 20);
    chk("t5_new_count", a_log.size() - base, 1);
    if (a_log.size() - base == 1) chk("t5_new_a", a_log[base], 39'h5040);

    // Degenerate descriptors are consumed and dropped
    @(negedge clk);
    base = a_log.size();
    desc_a(39'h1000, 8'd0, 8'd5);
    #1 chk("t6_s0_yumi", ia.yumi_o, 1);
    @(negedge clk) ia.v_i = 1'b0;
    #1 chk("t6_s0_drop_busy", ia.busy_o, 1);
    chk("t6_s0_drop_pfv", ia.pf_v_o, 0);
    @(negedge clk) #1 chk("t6_s0_idle", ia.busy_o, 0);
    desc_a(39'h1000, 8'd64, 8'd0);
    #1 chk("t6_r0_yumi", ia.yumi_o, 1);
    @(negedge clk) ia.v_i = 1'b0;
    #1 chk("t6_r0_drop_pfv", ia.pf_v_o, 0);
    @(negedge clk) #1 chk("t6_r0_idle", ia.busy_o, 0);
    chk("t6_none", a_log.size() - base, 0);

    // Asynchronous reset during e_issue
    ia.pf_ready_and_i = 1'b0;
    desc_a(39'h6000, 8'd64, 8'd4);
    @(negedge clk) ia.v_i = 1'b0;
    @(negedge clk) #1 chk("t7_issue_v", ia.pf_v_o, 1);
    #2 rst_n = 1'b0;
    #1 chk("t7_rst_pfv", ia.pf_v_o, 0);
    chk("t7_rst_busy", ia.busy_o, 0);
    chk("t7_rst_yumi", ia.yumi_o, 0);
    chk("t7_rst_addr", ia.pf_vaddr_o, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
